// File: rtl/dlx_mem_bus_arbiter_pkg.sv
// Shared types and helpers for the DLX memory-bus arbiter.
// State encodings, select values and the 32-bit 2:1 mux.
package dlx_mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic logic [31:0] mux2_32(
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return s ? b : a;
  endfunction

endpackage

// File: rtl/dlx_mem_bus_arbiter_fsm.sv
// Ownership FSM: round-robin tie break and per-grant beat limit.
// Drives the registered mux select and the grant flags.
module bus_arb_fsm
  import dlx_mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int BEAT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic beat,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b
);

  arb_state_t        state;
  logic              last_b;
  logic [BEAT_W-1:0] cnt;
  logic              burst_end;
  logic              count_en;

  assign count_en  = beat && (MAX_BURST != 0);
  assign burst_end = count_en &&
                     (cnt == BEAT_W'(MAX_BURST - 1));

  // State, round-robin memory, beat counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= SEL_A;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      last_b <= 1'b1;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_a && (!req_b || last_b)) begin
            state <= OWN_A;
            sel   <= SEL_A;
            gnt_a <= 1'b1;
          end else if (req_b) begin
            state <= OWN_B;
            sel   <= SEL_B;
            gnt_b <= 1'b1;
          end
        end
        OWN_A: begin
          if (!req_a || (burst_end && req_b)) begin
            last_b <= 1'b0;
            cnt    <= '0;
            gnt_a  <= 1'b0;
            if (req_b) begin
              state <= OWN_B;
              sel   <= SEL_B;
              gnt_b <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (burst_end) begin
            cnt <= '0;
          end else if (count_en) begin
            cnt <= cnt + 1'b1;
          end
        end
        OWN_B: begin
          if (!req_b || (burst_end && req_a)) begin
            last_b <= 1'b1;
            cnt    <= '0;
            gnt_b  <= 1'b0;
            if (req_a) begin
              state <= OWN_A;
              sel   <= SEL_A;
              gnt_a <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (burst_end) begin
            cnt <= '0;
          end else if (count_en) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dlx_mem_bus_arbiter.sv
// Memory-port arbiter between the DLX core (A) and sharpening engine (B).
// Optional counters: define DLX_BUS_ARB_STATS_EN.
module dlx_mem_bus_arbiter
  import dlx_mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int BEAT_W    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_A,
  input  logic [31:0] ADDR_A,
  input  logic [31:0] WDATA_A,
  input  logic        WE_A,
  input  logic        REQ_B,
  input  logic [31:0] ADDR_B,
  input  logic [31:0] WDATA_B,
  input  logic        WE_B,
  input  logic        MEM_ACK,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        MEM_WE,
  output logic        SEL,
  output logic        GNT_A,
  output logic        GNT_B,
  output logic        ACK_A,
`ifdef DLX_BUS_ARB_STATS_EN
  output logic [31:0] STAT_BEATS_A,
  output logic [31:0] STAT_BEATS_B,
  output logic [31:0] STAT_WAIT_B,
`endif
  output logic        ACK_B
);

  logic beat;

  bus_arb_fsm #(
    .MAX_BURST (MAX_BURST),
    .BEAT_W    (BEAT_W)
  ) u_fsm (
    .clk   (CLK),
    .reset (RESET),
    .req_a (REQ_A),
    .req_b (REQ_B),
    .beat  (beat),
    .sel   (SEL),
    .gnt_a (GNT_A),
    .gnt_b (GNT_B)
  );

  assign MEM_ADDR  = mux2_32(SEL, ADDR_A, ADDR_B);
  assign MEM_WDATA = mux2_32(SEL, WDATA_A, WDATA_B);

  assign MEM_REQ = (GNT_A & REQ_A) | (GNT_B & REQ_B);
  assign MEM_WE  = ((GNT_A & WE_A) | (GNT_B & WE_B)) & MEM_REQ;
  assign beat    = MEM_REQ & MEM_ACK;
  assign ACK_A   = beat & GNT_A;
  assign ACK_B   = beat & GNT_B;

`ifdef DLX_BUS_ARB_STATS_EN
  // Per-requester beat totals and B's waiting cycles
  always_ff @(posedge CLK) begin
    if (RESET) begin
      STAT_BEATS_A <= '0;
      STAT_BEATS_B <= '0;
      STAT_WAIT_B  <= '0;
    end else begin
      if (ACK_A)
        STAT_BEATS_A <= STAT_BEATS_A + 32'd1;
      if (ACK_B)
        STAT_BEATS_B <= STAT_BEATS_B + 32'd1;
      if (REQ_B && !GNT_B)
        STAT_WAIT_B <= STAT_WAIT_B + 32'd1;
    end
  end
`endif

endmodule
